// File: rtl/ifu_inst_buffer_if.sv
// rtl/ifu_inst_buffer_if.sv - predecode/decode handshake bundle for the instruction buffer
interface ifu_inst_buffer_if #(
  parameter int BLOCK_INST_SIZE = 8,
  parameter int FETCH_WIDTH     = 4,
  parameter int FSQ_WIDTH       = 4
);
  localparam int NUM_W = $clog2(BLOCK_INST_SIZE) + 1;

  logic [BLOCK_INST_SIZE-1:0]               in_en;
  logic [NUM_W-1:0]                         in_num;
  logic [BLOCK_INST_SIZE-1:0][31:0]         in_inst;
  logic [FSQ_WIDTH-1:0]                     in_fsqIdx;
  logic                                     full;
  logic                                     out_ready;
  logic [FETCH_WIDTH-1:0]                   out_en;
  logic [FETCH_WIDTH-1:0][31:0]             out_inst;
  logic [FETCH_WIDTH-1:0][FSQ_WIDTH-1:0]    out_fsqIdx;
  logic                                     flush;

  // predecode + decode side
  modport master (
    output in_en, in_num, in_inst, in_fsqIdx, out_ready, flush,
    input  full, out_en, out_inst, out_fsqIdx
  );

  // the buffer itself
  modport slave (
    input  in_en, in_num, in_inst, in_fsqIdx, out_ready, flush,
    output full, out_en, out_inst, out_fsqIdx
  );
endinterface

// File: rtl/ifu_inst_buffer.sv
// rtl/ifu_inst_buffer.sv - multi-enqueue/multi-dequeue circular instruction FIFO (optional IFU_IBUF_BYPASS_EN)
module ifu_inst_buffer #(
  parameter int BLOCK_INST_SIZE = 8,
  parameter int FETCH_WIDTH     = 4,
  parameter int DEPTH           = 32,
  parameter int FSQ_WIDTH       = 4
) (
  input  logic             clk,
  input  logic             rst,
  ifu_inst_buffer_if.slave ibuf
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [31:0]          mem_inst [DEPTH];
  logic [FSQ_WIDTH-1:0] mem_fsq  [DEPTH];

  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [CNT_W-1:0] count;
  logic             full_q;

  logic             enq_fire;
  logic [CNT_W-1:0] enq_num;
  logic [CNT_W-1:0] out_num;
  logic [CNT_W-1:0] win_num;
  logic [CNT_W-1:0] skip_num;
  logic [CNT_W-1:0] deq_num;
  logic [CNT_W-1:0] next_count;
  logic [CNT_W-1:0] free_next;
  logic [PTR_W-1:0] skip_ptr;
`ifdef IFU_IBUF_BYPASS_EN
  logic             byp_act;
`endif

  // Occupancy arithmetic: how many enter, how many leave, what the window shows.
  always_comb begin
    enq_fire = (ibuf.in_num != '0) && !full_q && !ibuf.flush;
    enq_num  = enq_fire ? CNT_W'(ibuf.in_num) : '0;
    out_num  = (count < CNT_W'(FETCH_WIDTH)) ? count : CNT_W'(FETCH_WIDTH);
    deq_num  = (ibuf.out_ready && !ibuf.flush) ? out_num : '0;
    win_num  = out_num;
    skip_num = '0;
`ifdef IFU_IBUF_BYPASS_EN
    // An empty buffer forwards the head of the incoming block directly;
    // whatever decode takes this cycle is never stored.
    byp_act = enq_fire && (count == '0);
    if (byp_act) begin
      win_num = (enq_num < CNT_W'(FETCH_WIDTH)) ? enq_num : CNT_W'(FETCH_WIDTH);
      if (ibuf.out_ready) begin
        skip_num = win_num;
      end
    end
`endif
    skip_ptr   = skip_num[PTR_W-1:0];
    next_count = count + enq_num - skip_num - deq_num;
    free_next  = CNT_W'(DEPTH) - next_count;
  end

  // Output window: oldest entries starting at head, modulo the ring size.
  always_comb begin
    for (int j = 0; j < FETCH_WIDTH; j++) begin
      ibuf.out_en[j]     = CNT_W'(j) < win_num;
      ibuf.out_inst[j]   = mem_inst[head + PTR_W'(j)];
      ibuf.out_fsqIdx[j] = mem_fsq[head + PTR_W'(j)];
`ifdef IFU_IBUF_BYPASS_EN
      if (byp_act) begin
        ibuf.out_inst[j]   = ibuf.in_inst[j];
        ibuf.out_fsqIdx[j] = ibuf.in_fsqIdx;
      end
`endif
    end
  end

  assign ibuf.full = full_q;

  // Pointer, occupancy and full-flag registers; flush behaves like reset.
  always_ff @(posedge clk) begin
    if (rst || ibuf.flush) begin
      head   <= '0;
      tail   <= '0;
      count  <= '0;
      full_q <= 1'b0;
    end else begin
      head   <= head + deq_num[PTR_W-1:0];
      tail   <= tail + enq_num[PTR_W-1:0] - skip_ptr;
      count  <= next_count;
      full_q <= free_next < CNT_W'(BLOCK_INST_SIZE);
    end
  end

  // Entry storage: write the non-forwarded slots contiguously from tail.
  always_ff @(posedge clk) begin
    for (int i = 0; i < BLOCK_INST_SIZE; i++) begin
      if (enq_fire && ibuf.in_en[i] && (CNT_W'(i) >= skip_num)) begin
        mem_inst[tail + PTR_W'(i) - skip_ptr] <= ibuf.in_inst[i];
        mem_fsq[tail + PTR_W'(i) - skip_ptr]  <= ibuf.in_fsqIdx;
      end
    end
  end
endmodule

// File: tb/tb_ifu_inst_buffer.sv
// tb/tb_ifu_inst_buffer.sv - self-checking bench for ifu_inst_buffer against a queue model
module tb_ifu_inst_buffer;
  localparam int BIS   = 8;
  localparam int FW    = 4;
  localparam int DEPTH = 32;
  localparam int FSQW  = 4;
  localparam int NUM_W = $clog2(BIS) + 1;

  typedef logic [FSQW+31:0] ent_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ifu_inst_buffer_if #(.BLOCK_INST_SIZE(BIS), .FETCH_WIDTH(FW), .FSQ_WIDTH(FSQW)) ibuf ();

  ifu_inst_buffer #(.BLOCK_INST_SIZE(BIS), .FETCH_WIDTH(FW), .DEPTH(DEPTH), .FSQ_WIDTH(FSQW)) dut (
    .clk  (clk),
    .rst  (rst),
    .ibuf (ibuf)
  );

  ent_t            mq[$];
  ent_t            win[$];
  bit              mfull;
  int              exp_n;
  logic [FW-1:0]   exp_en;
  int              total = 0;
  int              bad = 0;

  int              m_n;
  logic [31:0]     m_base;
  logic [FSQW-1:0] m_fsq;
  bit              m_rdy;
  bit              m_fl;
  bit              m_enq;

  // Drive one cycle of inputs and derive the expected visible window.
  task automatic set_in(int n, logic [31:0] base, logic [FSQW-1:0] fsq, bit rdy, bit fl);
    ibuf.in_num    = NUM_W'(n);
    ibuf.in_en     = BIS'((1 << n) - 1);
    for (int i = 0; i < BIS; i++) ibuf.in_inst[i] = (i < n) ? base + 32'(i) : $urandom();
    ibuf.in_fsqIdx = fsq;
    ibuf.out_ready = rdy;
    ibuf.flush     = fl;
    m_n = n; m_base = base; m_fsq = fsq; m_rdy = rdy; m_fl = fl;
    #1;
    m_enq = (n != 0) && !mfull && !fl;
    win = mq;
`ifdef IFU_IBUF_BYPASS_EN
    if (m_enq && mq.size() == 0)
      for (int i = 0; i < n; i++) win.push_back({fsq, base + 32'(i)});
`endif
    exp_n  = (win.size() < FW) ? win.size() : FW;
    exp_en = FW'((1 << exp_n) - 1);
  endtask

  // Advance one clock and apply the same cycle to the model.
  task automatic tick();
    @(posedge clk);
    if (rst || m_fl) begin
      mq.delete();
      mfull = 1'b0;
    end else begin
      if (m_enq) for (int i = 0; i < m_n; i++) mq.push_back({m_fsq, m_base + 32'(i)});
      if (m_rdy) repeat (exp_n) void'(mq.pop_front());
      mfull = (DEPTH - mq.size()) < BIS;
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    set_in(0, 0, 0, 0, 0);
    tick();
    tick();
    rst = 1'b0;
    set_in(0, 0, 0, 1, 0);
    total++; if (ibuf.out_en !== 4'h0) begin bad++; $display("FAIL reset out_en got=%h exp=0", ibuf.out_en); end
    total++; if (ibuf.full !== 1'b0) begin bad++; $display("FAIL reset full got=%b exp=0", ibuf.full); end
    tick();
  endtask

  task automatic test_single_block();
    for (int c = 0; c < 4; c++) begin
      if (c == 0) set_in(8, 32'h100, 4'd3, 1, 0);
      else        set_in(0, 0, 0, 1, 0);
      total++; if (ibuf.out_en !== exp_en) begin bad++; $display("FAIL single c=%0d out_en got=%h exp=%h", c, ibuf.out_en, exp_en); end
      for (int j = 0; j < exp_n; j++) begin
        total++; if ({ibuf.out_fsqIdx[j], ibuf.out_inst[j]} !== win[j]) begin bad++; $display("FAIL single c=%0d slot%0d got=%h exp=%h", c, j, {ibuf.out_fsqIdx[j], ibuf.out_inst[j]}, win[j]); end
      end
`ifndef IFU_IBUF_BYPASS_EN
      if (c == 1 || c == 2) begin
        total++; if (ibuf.out_en !== 4'hF) begin bad++; $display("FAIL single_const c=%0d out_en got=%h exp=f", c, ibuf.out_en); end
        for (int j = 0; j < FW; j++) begin
          total++;
          if (ibuf.out_inst[j] !== 32'h100 + 32'(4 * (c - 1) + j) || ibuf.out_fsqIdx[j] !== 4'd3) begin
            bad++; $display("FAIL single_const c=%0d slot%0d got=%h/%h exp=%h/3", c, j, ibuf.out_inst[j], ibuf.out_fsqIdx[j], 32'h100 + 32'(4 * (c - 1) + j));
          end
        end
      end
      if (c == 3) begin
        total++; if (ibuf.out_en !== 4'h0) begin bad++; $display("FAIL single_empty out_en got=%h exp=0", ibuf.out_en); end
      end
`endif
      tick();
    end
  endtask

  task automatic test_fill();
    set_in(0, 0, 0, 0, 1);
    tick();
    for (int c = 0; c < 15; c++) begin
      if (c < 5) set_in(8, 32'h200 + 32'(8 * c), FSQW'(c), 0, 0);
      else       set_in(0, 0, 0, 1, 0);
      total++; if (ibuf.out_en !== exp_en) begin bad++; $display("FAIL fill c=%0d out_en got=%h exp=%h", c, ibuf.out_en, exp_en); end
      total++; if (ibuf.full !== mfull) begin bad++; $display("FAIL fill c=%0d full got=%b exp=%b", c, ibuf.full, mfull); end
      for (int j = 0; j < exp_n; j++) begin
        total++; if ({ibuf.out_fsqIdx[j], ibuf.out_inst[j]} !== win[j]) begin bad++; $display("FAIL fill c=%0d slot%0d got=%h exp=%h", c, j, {ibuf.out_fsqIdx[j], ibuf.out_inst[j]}, win[j]); end
      end
      if (c == 4) begin
        total++; if (ibuf.full !== 1'b1) begin bad++; $display("FAIL fill_full got=%b exp=1", ibuf.full); end
      end
      if (c == 13) begin
        total++; if (ibuf.out_en !== 4'h0) begin bad++; $display("FAIL fill_drained out_en got=%h exp=0", ibuf.out_en); end
      end
      tick();
    end
  endtask

  task automatic test_wrap();
    set_in(0, 0, 0, 0, 1);
    tick();
    for (int c = 0; c < 16; c++) begin
      if (c < 3)       set_in(8, 32'h1000 + 32'(16 * c), FSQW'(c), 1, 0);
      else if (c == 3) set_in(4, 32'h1100, 4'd7, 1, 0);
      else if (c == 10) set_in(8, $urandom(), FSQW'($urandom()), 0, 0);
      else             set_in(0, 0, 0, 1, 0);
      if (c == 10) begin
        total++; if (dut.tail !== 5'd28 || dut.head !== 5'd28) begin bad++; $display("FAIL wrap_ptr head=%0d tail=%0d exp=28/28", dut.head, dut.tail); end
      end
      total++; if (ibuf.out_en !== exp_en) begin bad++; $display("FAIL wrap c=%0d out_en got=%h exp=%h", c, ibuf.out_en, exp_en); end
      for (int j = 0; j < exp_n; j++) begin
        total++; if ({ibuf.out_fsqIdx[j], ibuf.out_inst[j]} !== win[j]) begin bad++; $display("FAIL wrap c=%0d slot%0d got=%h exp=%h", c, j, {ibuf.out_fsqIdx[j], ibuf.out_inst[j]}, win[j]); end
      end
      tick();
    end
  endtask

  task automatic test_simultaneous();
    set_in(0, 0, 0, 0, 1);
    tick();
    for (int c = 0; c < 5; c++) begin
      if (c == 0)      set_in(6, 32'h300, 4'd1, 0, 0);
      else if (c == 1) set_in(5, 32'h400, 4'd2, 1, 0);
      else             set_in(0, 0, 0, 1, 0);
      total++; if (ibuf.out_en !== exp_en) begin bad++; $display("FAIL simul c=%0d out_en got=%h exp=%h", c, ibuf.out_en, exp_en); end
      for (int j = 0; j < exp_n; j++) begin
        total++; if ({ibuf.out_fsqIdx[j], ibuf.out_inst[j]} !== win[j]) begin bad++; $display("FAIL simul c=%0d slot%0d got=%h exp=%h", c, j, {ibuf.out_fsqIdx[j], ibuf.out_inst[j]}, win[j]); end
      end
      if (c == 2) begin
        total++; if (ibuf.out_en !== 4'hF || ibuf.out_inst[0] !== 32'h304 || ibuf.out_inst[2] !== 32'h400) begin
          bad++; $display("FAIL simul_const out_en=%h inst0=%h inst2=%h exp=f/304/400", ibuf.out_en, ibuf.out_inst[0], ibuf.out_inst[2]);
        end
      end
      tick();
    end
  endtask

  task automatic test_flush();
    set_in(0, 0, 0, 0, 1);
    tick();
    for (int c = 0; c < 7; c++) begin
      if (c == 0)      set_in(8, 32'h600, 4'd4, 0, 0);
      else if (c == 1) set_in(2, 32'h700, 4'd5, 0, 0);
      else if (c == 2) set_in(8, 32'hDEAD0000, 4'd9, 1, 1);
      else             set_in(0, 0, 0, 1, 0);
      total++; if (ibuf.out_en !== exp_en) begin bad++; $display("FAIL flush c=%0d out_en got=%h exp=%h", c, ibuf.out_en, exp_en); end
      for (int j = 0; j < exp_n; j++) begin
        total++; if ({ibuf.out_fsqIdx[j], ibuf.out_inst[j]} !== win[j]) begin bad++; $display("FAIL flush c=%0d slot%0d got=%h exp=%h", c, j, {ibuf.out_fsqIdx[j], ibuf.out_inst[j]}, win[j]); end
      end
      if (c >= 3) begin
        total++; if (ibuf.out_en !== 4'h0 || ibuf.full !== 1'b0) begin bad++; $display("FAIL flush_empty c=%0d out_en=%h full=%b exp=0/0", c, ibuf.out_en, ibuf.full); end
      end
      tick();
    end
  endtask

`ifdef IFU_IBUF_BYPASS_EN
  task automatic test_bypass();
    set_in(0, 0, 0, 0, 1);
    tick();
    for (int c = 0; c < 3; c++) begin
      if (c == 0) set_in(6, 32'h500, 4'd6, 1, 0);
      else        set_in(0, 0, 0, 1, 0);
      total++; if (ibuf.out_en !== exp_en) begin bad++; $display("FAIL bypass c=%0d out_en got=%h exp=%h", c, ibuf.out_en, exp_en); end
      for (int j = 0; j < exp_n; j++) begin
        total++; if ({ibuf.out_fsqIdx[j], ibuf.out_inst[j]} !== win[j]) begin bad++; $display("FAIL bypass c=%0d slot%0d got=%h exp=%h", c, j, {ibuf.out_fsqIdx[j], ibuf.out_inst[j]}, win[j]); end
      end
      if (c == 0) begin
        total++; if (ibuf.out_en !== 4'hF || ibuf.out_inst[3] !== 32'h503) begin bad++; $display("FAIL bypass_same out_en=%h inst3=%h exp=f/503", ibuf.out_en, ibuf.out_inst[3]); end
      end
      if (c == 1) begin
        total++; if (ibuf.out_en !== 4'h3 || ibuf.out_inst[1] !== 32'h505) begin bad++; $display("FAIL bypass_next out_en=%h inst1=%h exp=3/505", ibuf.out_en, ibuf.out_inst[1]); end
      end
      tick();
    end
  endtask
`endif

  task automatic test_random();
    set_in(0, 0, 0, 0, 1);
    tick();
    for (int c = 0; c < 500; c++) begin
      set_in($urandom_range(0, BIS), $urandom(), FSQW'($urandom()),
             $urandom_range(0, 1) == 1, $urandom_range(0, 30) == 0);
      total++; if (ibuf.out_en !== exp_en) begin bad++; $display("FAIL random c=%0d out_en got=%h exp=%h", c, ibuf.out_en, exp_en); end
      total++; if (ibuf.full !== mfull) begin bad++; $display("FAIL random c=%0d full got=%b exp=%b", c, ibuf.full, mfull); end
      for (int j = 0; j < exp_n; j++) begin
        total++; if ({ibuf.out_fsqIdx[j], ibuf.out_inst[j]} !== win[j]) begin bad++; $display("FAIL random c=%0d slot%0d got=%h exp=%h", c, j, {ibuf.out_fsqIdx[j], ibuf.out_inst[j]}, win[j]); end
      end
      tick();
    end
  endtask

  initial begin
    mfull = 1'b0;
    test_reset();
    test_single_block();
    test_fill();
    test_wrap();
    test_simultaneous();
    test_flush();
`ifdef IFU_IBUF_BYPASS_EN
    test_bypass();
`endif
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ifu_inst_buffer.md
# ifu_inst_buffer

Instruction buffer between predecode and decode. Accepts up to `BLOCK_INST_SIZE` predecoded instructions per cycle, each tagged with its FSQ index, from the predecode stage, and delivers up to `FETCH_WIDTH` instructions per cycle in program order to the decode stage. It is a circular FIFO with multi-entry enqueue and multi-entry dequeue. It absorbs the rate mismatch between fetch blocks and decode width, and provides the fetch-side backpressure point.

## Interface
Parameters:
- `BLOCK_INST_SIZE`, 8: maximum instructions enqueued per cycle.
- `FETCH_WIDTH`, 4: maximum instructions dequeued per cycle.
- `DEPTH`, 32: entries. Must be a power of two and at least 2×`BLOCK_INST_SIZE`.
- `FSQ_WIDTH`, 4: FSQ index width.

Ports:
- `clk`  in  1  clock. The block uses this single clock.
- `rst`  in  1  reset, synchronous, active-high.
- `in_en`  in  `BLOCK_INST_SIZE`  per-slot valid mask. Must be low-packed (contiguous from bit 0).
- `in_num`  in  clog2(`BLOCK_INST_SIZE`)+1  number of valid slots. Equals popcount(`in_en`).
- `in_inst`  in  `BLOCK_INST_SIZE`×32  instruction words.
- `in_fsqIdx`  in  `FSQ_WIDTH`  FSQ index shared by the whole block.
- `full`  out  1  registered. Asserted when free entries < `BLOCK_INST_SIZE`. Predecode must hold while it is high.
- `out_ready`  in  1  decode accepts this cycle.
- `out_en`  out  `FETCH_WIDTH`  per-slot valid, low-packed.
- `out_inst`  out  `FETCH_WIDTH`×32  instructions, oldest in slot 0.
- `out_fsqIdx`  out  `FETCH_WIDTH`×`FSQ_WIDTH`  per-slot FSQ index.
- `flush`  in  1  redirect or squash. Empties the buffer.

## Operation
- **Storage:** `DEPTH` entries of {inst[31:0], fsqIdx}.
- **Pointers:** `head` and `tail`, each clog2(`DEPTH`) bits, wrap modulo `DEPTH`. A separate `count` register is clog2(`DEPTH`)+1 bits.
- **Enqueue:**
  - Enqueue fires when `in_num`≠0 and !`full` and !`flush`.
  - Slot i is written to entry (`tail`+i) mod `DEPTH` for i<`in_num`.
  - `tail` += `in_num`.
  - Input presented while `full`=1 is ignored. The sender is responsible for holding it.
- **Dequeue:**
  - `out_en` slot j = (j < min(`count`, `FETCH_WIDTH`)).
  - `out_inst[j]` is the entry at (`head`+j) mod `DEPTH`.
  - When `out_ready` and !`flush`: `head` += popcount(`out_en`).
  - Dequeue is all-or-nothing on `out_ready`. There is no partial accept.
- **Count update:** `count` ← `count` + enq_num − deq_num. Simultaneous enqueue and dequeue are both applied.
- **Full:** `full` ← (`DEPTH` − next_count) < `BLOCK_INST_SIZE`, computed from the post-update count.
- **Flush** has priority over everything:
  - Next cycle: `head`=`tail`=0, `count`=0, `full`=0.
  - Same-cycle input is dropped and same-cycle output is not consumed.
  - Entry contents are not cleared.
- **Wrap-around:** enqueue and dequeue windows that straddle entry `DEPTH`−1→0 must be handled by modulo indexing, with no bubble.
- **Reset:** `head`=`tail`=`count`=0, `full`=0, so `out_en`=0 in the first cycle after reset. Storage is not reset.

## Timing
- **Latency (bypass disabled):** input enqueued in cycle N appears on `out_en` in cycle N+1 at the earliest.
- **Outputs:** `out_*` are combinational from registered state (`head`, `count`, storage) only. There is no combinational path from `out_ready` to `out_*`.
- **Full:** `full` is a register and updates one cycle after the enqueue that crosses the threshold. The threshold of `BLOCK_INST_SIZE` guarantees a block presented in the cycle `full` rises still fits.
- **Throughput:** `FETCH_WIDTH` instructions per cycle sustained while `count` ≥ `FETCH_WIDTH` and `out_ready`=1.
- **Flush:** `flush` in cycle N gives `out_en`=0 in cycle N+1. A new block is accepted from cycle N+1.

## Configuration
- Macro: `IFU_IBUF_BYPASS_EN`.
- **Defined:**
  - Applies when `count`=0 and an enqueue fires.
  - The first min(`in_num`, `FETCH_WIDTH`) instructions drive `out_*` in the same cycle.
  - If `out_ready`=1, those instructions are consumed without being written.
  - The remainder is written starting at `tail`.
  - If `out_ready`=0, all instructions are written normally.
  - Empty-buffer latency is 0 cycles. This adds an `in_*`→`out_*` combinational path.
- **Undefined:** no bypass. 1-cycle minimum latency and registered-only output paths.

## Test plan
- **Reset then single block:** reset, then `in_num`=8 with insts 0x100..0x107, fsqIdx 3, `out_ready`=1.
  - Cycle +1: `out_en`=4'hF, insts 0x100..0x103, all `out_fsqIdx`=3.
  - Cycle +2: insts 0x104..0x107.
  - Cycle +3: `out_en`=0.
- **Fill to full:** `out_ready`=0, enqueue 8 per cycle for 4 cycles (DEPTH 32).
  - `full` rises after the 4th enqueue, with `count`=32.
  - A 5th block presented while `full`=1 is ignored; `count` stays 32.
- **Wrap-around:** drive `head`=`tail`=28 via enqueue/dequeue history, then enqueue 8.
  - Entries 28..31 and 0..3 are written.
  - Dequeued order is preserved across the wrap.
- **Simultaneous enqueue/dequeue:** `count`=6, enqueue 5, `out_ready`=1.
  - Next cycle `count`=7.
  - Oldest 4 instructions are out; the remaining order is intact.
- **Flush mid-operation:** `count`=10, assert `flush` together with an 8-instruction enqueue.
  - Next cycle: `out_en`=0, `count`=0, `full`=0.
  - The dropped block never appears at the output.
- **Bypass (macro defined):** empty buffer, enqueue 6, `out_ready`=1.
  - Same cycle: `out_en`=4'hF carrying the first 4 instructions.
  - Next cycle: `out_en`=4'h3 carrying instructions 5..6.
